// File: rtl/coherence_bus_arbiter.sv
// Round-robin responder for the snooping coherence bus; sole driver of bus_rx.
// Define COHERENCE_BUS_ARB_STATS_EN to add saturating read/write broadcast counters.
module coherence_bus_arbiter #(
    parameter int CACHE_COUNT = 4,
    parameter int ADDR_WIDTH  = 8,
    localparam int MSG_W      = ADDR_WIDTH + 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CACHE_COUNT*MSG_W-1:0] req_msg,
    input  logic [CACHE_COUNT-1:0]       req_enable,
    output logic [CACHE_COUNT-1:0]       req_sent,
    output logic [MSG_W-1:0]             bus_rx,
    output logic                         busy,
    output logic [1:0]                   dbg_state
`ifdef COHERENCE_BUS_ARB_STATS_EN
    ,
    output logic [15:0]                  stat_reads,
    output logic [15:0]                  stat_writes
`endif
);

    // Handshake: a requester holds req_enable high with a stable message until it sees
    // its one-cycle req_sent pulse; the GAP cycle gives it time to drop enable.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BCAST = 2'd1, ST_GAP = 2'd2} state_t;

    state_t                   r_state;
    logic [1:0]               r_rr_last;
    logic [MSG_W-1:0]         r_bus_rx;
    logic [CACHE_COUNT-1:0]   r_req_sent;
    logic                     r_busy;

    logic                     w_found;
    logic [1:0]               w_winner;
    int                       w_dist;
    int                       w_best;
    logic [MSG_W-1:0]         w_msg;
    logic [CACHE_COUNT-1:0]   w_onehot;

    // Distance from the last winner decides priority: the smallest distance wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'd0;
        w_dist   = 0;
        w_best   = 0;
        for (int i = 0; i < CACHE_COUNT; i++) begin
            w_dist = (i + CACHE_COUNT - 1 - int'(r_rr_last)) % CACHE_COUNT;
            if (req_enable[i] && (!w_found || w_dist < w_best)) begin
                w_found  = 1'b1;
                w_best   = w_dist;
                w_winner = 2'(i);
            end
        end
    end

    always_comb begin
        w_msg    = '0;
        w_onehot = '0;
        for (int i = 0; i < CACHE_COUNT; i++) begin
            if (w_winner == 2'(i)) begin
                w_msg       = req_msg[i*MSG_W +: MSG_W];
                w_onehot[i] = w_found;
            end
        end
    end

`ifdef COHERENCE_BUS_ARB_STATS_EN
    logic [15:0] r_stat_reads;
    logic [15:0] r_stat_writes;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_last  <= 2'(CACHE_COUNT - 1);
            r_bus_rx   <= '0;
            r_req_sent <= '0;
            r_busy     <= 1'b0;
`ifdef COHERENCE_BUS_ARB_STATS_EN
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        // ID, valid and reserved fields are owned by the arbiter, not the sender.
                        r_bus_rx   <= {1'b0, w_msg[ADDR_WIDTH+3:3], 1'b1, w_winner};
                        r_req_sent <= w_onehot;
                        r_rr_last  <= w_winner;
                        r_busy     <= 1'b1;
                        r_state    <= ST_BCAST;
`ifdef COHERENCE_BUS_ARB_STATS_EN
                        if (w_msg[3]) begin
                            if (r_stat_reads != 16'hFFFF) r_stat_reads <= r_stat_reads + 16'd1;
                        end else begin
                            if (r_stat_writes != 16'hFFFF) r_stat_writes <= r_stat_writes + 16'd1;
                        end
`endif
                    end
                end
                ST_BCAST: begin
                    r_bus_rx[2] <= 1'b0;
                    r_req_sent  <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= ST_GAP;
                end
                ST_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_rx    = r_bus_rx;
    assign req_sent  = r_req_sent;
    assign busy      = r_busy;
    assign dbg_state = r_state;
`ifdef COHERENCE_BUS_ARB_STATS_EN
    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: slot-level model compared every cycle plus literal pins.
module tb_coherence_bus_arbiter;

    localparam int CC    = 4;
    localparam int AW    = 8;
    localparam int MSG_W = AW + 5;

    logic                  clock;
    logic                  reset;
    logic [CC*MSG_W-1:0]   req_msg;
    logic [CC-1:0]         req_enable;
    logic [CC-1:0]         req_sent;
    logic [MSG_W-1:0]      bus_rx;
    logic                  busy;
    logic [1:0]            dbg_state;
`ifdef COHERENCE_BUS_ARB_STATS_EN
    logic [15:0]           stat_reads;
    logic [15:0]           stat_writes;
`endif

    coherence_bus_arbiter #(.CACHE_COUNT(CC), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_msg    (req_msg),
        .req_enable (req_enable),
        .req_sent   (req_sent),
        .bus_rx     (bus_rx),
        .busy       (busy),
        .dbg_state  (dbg_state)
`ifdef COHERENCE_BUS_ARB_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    logic [1:0] idle_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Slot view: a grant makes the message visible for one cycle, then two more busy-ish
    // cycles pass (valid dropped, then idle) before the next request can be taken.
    logic [MSG_W-1:0] m_bus;
    logic [CC-1:0]    m_sent;
    logic             m_busy;
    int               m_cool;
    int               m_last;
    int               m_reads;
    int               m_writes;

    always @(posedge clock) begin
        logic [63:0] all;
        logic [MSG_W-1:0] msg;
        int w;
        if (reset) begin
            m_bus = '0; m_sent = '0; m_busy = 1'b0; m_cool = 0; m_last = CC - 1;
            m_reads = 0; m_writes = 0;
        end else if (m_cool > 0) begin
            m_cool--;
            m_bus[2] = 1'b0;
            m_sent = '0;
            m_busy = (m_cool > 0);
        end else if (req_enable != '0) begin
            w = -1;
            for (int j = 1; j <= CC; j++)
                if (w < 0 && req_enable[(m_last + j) % CC]) w = (m_last + j) % CC;
            all = 64'(req_msg);
            msg = MSG_W'(all >> (w * MSG_W));
            m_bus = msg;
            m_bus[1:0] = 2'(w);
            m_bus[2] = 1'b1;
            m_bus[MSG_W-1] = 1'b0;
            m_sent = '0;
            m_sent[w] = 1'b1;
            m_busy = 1'b1;
            m_cool = 2;
            m_last = w;
            if (msg[3]) begin if (m_reads < 65535) m_reads++; end
            else begin if (m_writes < 65535) m_writes++; end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clock) begin
        if (mon_on) begin
            chk("bus_rx", 32'(bus_rx), 32'(m_bus));
            chk("req_sent", 32'(req_sent), 32'(m_sent));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("sent_onehot", 32'($countones(req_sent) <= 1), 32'd1);
            chk("dbg_idle", 32'(dbg_state == idle_code), 32'(!m_busy));
`ifdef COHERENCE_BUS_ARB_STATS_EN
            chk("stat_reads", 32'(stat_reads), 32'(m_reads));
            chk("stat_writes", 32'(stat_writes), 32'(m_writes));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [MSG_W-1:0] mk(input logic [AW-1:0] addr, input logic op,
                                            input logic [1:0] id, input logic vld, input logic rsv);
        return {rsv, addr, op, vld, id};
    endfunction

    task automatic set_msg(input int port, input logic [MSG_W-1:0] m);
        req_msg[port*MSG_W +: MSG_W] = m;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        req_enable = '0;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Directed enable masks with hold times for the mixed-traffic pass.
    logic [CC-1:0] mask_tab [8] = '{4'b1010, 4'b0001, 4'b1111, 4'b0110, 4'b1000, 4'b0000, 4'b0101, 4'b1100};
    int            hold_tab [8] = '{5, 2, 9, 4, 1, 3, 7, 6};
    logic [CC-1:0] grant_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        req_enable = '0;
        req_msg = '0;
        @(negedge clock);
        do_reset(2);
        idle_code = dbg_state;
        mon_on = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_bus", 32'(bus_rx), 32'd0);
            chk("idle_sent", 32'(req_sent), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Single write from port 2.
        set_msg(2, mk(8'h5A, 1'b0, 2'd0, 1'b0, 1'b0));
        req_enable = 4'b0100;
        step(1);
        chk("p2_bcast_bus", 32'(bus_rx), 32'h05A6);
        chk("p2_bcast_sent", 32'(req_sent), 32'h4);
        req_enable = '0;
        step(1);
        chk("p2_gap_bus", 32'(bus_rx), 32'h05A2);
        chk("p2_gap_sent", 32'(req_sent), 32'h0);
        chk("p2_gap_busy", 32'(busy), 32'd1);
        step(1);
        chk("p2_idle_busy", 32'(busy), 32'd0);

        // All four continuously: grants rotate 0,1,2,3,0 at cycles 1,4,7,10,13.
        for (int p = 0; p < CC; p++) set_msg(p, mk(8'h10 + 8'(p), p[0], 2'(p), 1'b1, 1'b0));
        do_reset(1);
        req_enable = 4'b1111;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clock);
            if ((n % 3) == 1) chk("rr_grant", 32'(req_sent), 32'(grant_exp[(n-1)/3]));
        end
        req_enable = '0;
        step(3);

        // Sender-supplied ID/valid/reserved fields are overridden.
        do_reset(1);
        set_msg(1, mk(8'hC3, 1'b1, 2'd3, 1'b0, 1'b1));
        req_enable = 4'b0010;
        step(1);
        chk("p1_override_bus", 32'(bus_rx), 32'h0C3D);
        req_enable = '0;
        step(3);

        // Reset during BCAST aborts the slot; the still-enabled port 0 wins first again.
        do_reset(1);
        set_msg(0, mk(8'h77, 1'b1, 2'd0, 1'b0, 1'b0));
        req_enable = 4'b0011;
        step(1);
        chk("rst_pre_sent", 32'(req_sent), 32'h1);
        reset = 1'b1;
        step(1);
        chk("rst_bus", 32'(bus_rx), 32'h0);
        chk("rst_sent", 32'(req_sent), 32'h0);
        reset = 1'b0;
        step(1);
        chk("rst_regrant", 32'(req_sent), 32'h1);
        req_enable = '0;
        step(3);

        // Withdrawn request: port 3 asserts only during BCAST/GAP of another grant.
        req_enable = 4'b0100;
        step(1);
        req_enable = 4'b1000;
        step(1);
        req_enable = '0;
        step(1);
        chk("withdraw_sent", 32'(req_sent), 32'h0);
        step(1);
        chk("withdraw_bus_valid", 32'(bus_rx[2]), 32'd0);

        // Mixed traffic, model-checked every cycle.
        for (int t = 0; t < 8; t++) begin
            for (int p = 0; p < CC; p++)
                set_msg(p, mk(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0));
            req_enable = mask_tab[t];
            step(hold_tab[t]);
        end
        req_enable = '0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- Responder end of the snooping coherence bus: collects bus messages from up to four cache instances, picks one per slot round-robin, and broadcasts it to every cache's receive input.
- Handshakes each requester with a one-cycle sent pulse.
- Sits between the cache array and the shared bus_rx net; sole driver of bus_rx.

Parameters:
- CACHE_COUNT, 4, number of attached caches (1..4; ID field is 2 bits)
- ADDR_WIDTH, 8, cache address width; message width MSG_W = ADDR_WIDTH + 5

Ports:
- clock  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- req_msg  input  CACHE_COUNT*MSG_W  packed requester messages; slice i = cache i
- req_enable  input  CACHE_COUNT  level request per cache; held with message stable until sent
- req_sent  output  CACHE_COUNT  one-cycle grant/consumed pulse per cache
- bus_rx  output  MSG_W  broadcast message to all caches
- busy  output  1  high in BCAST and GAP states

Behaviour:
- Message format, all ports: [1:0] sender ID, [2] valid, [3] op (1 = read, 0 = write/invalidate), [ADDR_WIDTH+3:4] address, [ADDR_WIDTH+4] reserved (0).
- Reset: bus_rx = 0, req_sent = 0, busy = 0, state = IDLE, rr_last = CACHE_COUNT-1 so port 0 wins first. Reset in any state aborts the slot; the abandoned message is not rebroadcast.
- FSM: IDLE -> BCAST -> GAP -> IDLE.
- IDLE: at a posedge with any req_enable high, winner w = first enabled index scanning rr_last+1, rr_last+2, ... mod CACHE_COUNT.
  - Registered: bus_rx <= req_msg[w] with [1:0] forced to w, [2] forced 1, [ADDR_WIDTH+4] forced 0; req_sent[w] <= 1; rr_last <= w; state <= BCAST.
  - No request: stay IDLE, bus_rx[2] stays 0.
- BCAST (exactly one cycle): bus_rx valid, req_sent[w] high. Next edge: bus_rx[2] <= 0 (other fields hold), req_sent <= 0, state <= GAP.
- GAP (exactly one cycle): ignores req_enable so the served requester can drop enable; next edge -> IDLE.
- Throughput: one broadcast per 3 cycles max; latency from enable sampled in IDLE to valid on bus_rx = 1 cycle.
- At most one req_sent bit high in any cycle; req_sent never high outside BCAST.
- Request withdrawn (enable low) before being sampled in IDLE: never broadcast, no sent pulse.
- Enable still high after GAP: treated as a new request (back-to-back traffic from one cache legal).
- Simultaneous requests: round-robin only; fairness bound = CACHE_COUNT-1 slots of waiting.
- Ports >= CACHE_COUNT do not exist; req_enable width exactly CACHE_COUNT.

Optional Feature:
- Macro: COHERENCE_BUS_ARB_STATS_EN.
- Defined: adds outputs stat_reads [15:0] and stat_writes [15:0], saturating counters incremented on the edge entering BCAST according to the broadcast op bit; cleared by reset; hold at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then idle 10 cycles -> bus_rx = 0, req_sent = 0, busy = 0 throughout.
- Port 2 only, addr 8'h5A, op write, enable at cycle 0 -> cycle 1: bus_rx[2] = 1, [1:0] = 2, [3] = 0, addr 8'h5A, req_sent = 4'b0100; cycle 2: bus_rx[2] = 0; cycle 3 back in IDLE.
- All four ports enabled continuously after reset -> grants 0, 1, 2, 3, 0 at BCAST cycles 1, 4, 7, 10, 13.
- Port 1 sends message with ID field 3 and valid bit 0 -> broadcast shows ID 1, valid 1.
- Reset asserted during BCAST of port 0 -> next cycle bus_rx = 0, req_sent = 0; port 0 still enabled -> granted first after reset.
- With COHERENCE_BUS_ARB_STATS_EN: 3 reads, 2 writes -> stat_reads = 3, stat_writes = 2; force 70000 reads -> stat_reads = 16'hFFFF.
